// File: rtl/calc_operand_sequencer_if.sv
// Calculator front-end bundle: switch bank and raw buttons in, operand pair,
// opcode and status out.
interface calc_operand_sequencer_if;
  logic [3:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [1:0] op_sel;
  logic       operands_valid;
  logic       div_by_zero;
  logic [1:0] state;

  modport master (
    input  sw, btn_enter, btn_clear,
    output op_a, op_b, op_sel, operands_valid, div_by_zero, state
  );

  modport slave (
    output sw, btn_enter, btn_clear,
    input  op_a, op_b, op_sel, operands_valid, div_by_zero, state
  );
endinterface

// File: rtl/calc_operand_sequencer.sv
// Operand entry front-end: synchronises, debounces and edge-detects ENTER/CLEAR,
// then steps a 4-state entry FSM that holds A, B and opcode for the calculator.
//
// state  | meaning
// GET_A  | waiting for ENTER to capture operand A from sw
// GET_B  | waiting for ENTER to capture operand B from sw
// GET_OP | waiting for ENTER to capture opcode from sw[1:0]
// SHOW   | operands stable, calculator result valid; ENTER returns to GET_A
module calc_operand_sequencer #(
  parameter int DB_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  calc_operand_sequencer_if.master  bus
);

  localparam int                CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    GET_A  = 2'b00,
    GET_B  = 2'b01,
    GET_OP = 2'b10,
    SHOW   = 2'b11
  } state_t;

  // Bit 0 is ENTER, bit 1 is CLEAR throughout the button path.
  logic [1:0]       btn_raw;
  logic [1:0]       s1, s2, db, db_q, pulse;
  logic [CNT_W-1:0] cnt [2];
  logic             enter_p, clear_p;

  assign btn_raw = {bus.btn_clear, bus.btn_enter};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      db_q <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign pulse   = db & ~db_q;
  assign enter_p = pulse[0];
  assign clear_p = pulse[1];

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [1:0] sel_q, sel_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    // Clear outranks a coincident enter; the enter pulse is simply dropped.
    if (clear_p) begin
      state_d = GET_A;
      a_d     = '0;
      b_d     = '0;
      sel_d   = '0;
    end else if (enter_p) begin
      unique case (state_q)
        GET_A: begin
          a_d     = bus.sw;
          state_d = GET_B;
        end
        GET_B: begin
          b_d     = bus.sw;
          state_d = GET_OP;
        end
        GET_OP: begin
          sel_d   = bus.sw[1:0];
          state_d = SHOW;
        end
        SHOW: state_d = GET_A;
        default: state_d = GET_A;
      endcase
    end
  end

  assign bus.op_a           = a_q;
  assign bus.op_b           = b_q;
  assign bus.op_sel         = sel_q;
  assign bus.state          = state_q;
  assign bus.operands_valid = (state_q == SHOW);
  assign bus.div_by_zero    = (state_q == SHOW) && (sel_q == 2'b11) && (b_q == 4'd0);

endmodule
